// File: rtl/bfs_run_pkg.sv
// bfs_run_pkg: shared state encoding and default counter width for the BFS run controller
package bfs_run_pkg;
    localparam int CNT_W_DEFAULT = 64;
    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} t_run_state;
endpackage

// File: rtl/bfs_sat_counter.sv
// bfs_sat_counter: up-counter with synchronous clear and enable that saturates at all-ones
module bfs_sat_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (clr) count <= '0;
        else if (en && count != '1) count <= count + W'(1);
endmodule

// File: rtl/bfs_run_ctrl.sv
// bfs_run_ctrl: sequences worklist init, BFS engine run, timeout and abort for one CSR-triggered run
module bfs_run_ctrl
    import bfs_run_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             SoftReset,
    input  logic             csr_go,
    input  logic [31:0]      cfg_capacity,
    input  logic [CNT_W-1:0] cfg_max_cycles,
    output logic             start_worklist,
    input  logic             wl_init_done,
    output logic             start_afu,
    input  logic             afu_finish,
    input  logic [CNT_W-1:0] afu_nodes,
    output logic             run_busy,
    output logic             run_done,
    output logic             run_timeout,
    output logic             run_error,
    output logic [CNT_W-1:0] run_cycles,
    output logic [CNT_W-1:0] nodes_latched
);
    t_run_state state, state_n;
    logic go_q, armed, go_edge, timeout_hit;
    logic start_worklist_n, start_afu_n, run_timeout_n, run_error_n, capture, cnt_clr, cnt_en;
    // armed stays low after reset until go is seen low, so a go held across reset cannot start a run
    assign go_edge     = csr_go & ~go_q & armed;
    assign cnt_en      = (state == RUN) & csr_go;
    assign timeout_hit = (state == RUN) && cfg_max_cycles != '0 && run_cycles == cfg_max_cycles - CNT_W'(1);
    always_comb begin
        state_n          = state;
        start_worklist_n = 1'b0;
        start_afu_n      = 1'b0;
        run_timeout_n    = run_timeout;
        run_error_n      = run_error;
        capture          = 1'b0;
        cnt_clr          = 1'b0;
        case (state)
            IDLE: if (go_edge) begin
                cnt_clr       = 1'b1;
                run_timeout_n = 1'b0;
                run_error_n   = cfg_capacity == '0;
                start_worklist_n = cfg_capacity != '0;
                state_n       = cfg_capacity != '0 ? INIT : DONE;
            end
            INIT: if (!csr_go) state_n = IDLE;
                else if (wl_init_done) begin
                    start_afu_n = 1'b1;
                    state_n     = RUN;
                end
            RUN: if (!csr_go) state_n = IDLE;
                else if (afu_finish || timeout_hit) begin
                    capture       = 1'b1;
                    run_timeout_n = ~afu_finish;
                    state_n       = DONE;
                end
            DONE: if (!csr_go) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge SoftReset)
        if (SoftReset) begin
            state          <= IDLE;
            go_q           <= 1'b0;
            armed          <= 1'b0;
            start_worklist <= 1'b0;
            start_afu      <= 1'b0;
            run_busy       <= 1'b0;
            run_done       <= 1'b0;
            run_timeout    <= 1'b0;
            run_error      <= 1'b0;
            nodes_latched  <= '0;
        end else begin
            state          <= state_n;
            go_q           <= csr_go;
            armed          <= armed | ~csr_go;
            start_worklist <= start_worklist_n;
            start_afu      <= start_afu_n;
            run_busy       <= state_n == INIT || state_n == RUN;
            run_done       <= state_n == DONE;
            run_timeout    <= run_timeout_n;
            run_error      <= run_error_n;
            nodes_latched  <= cnt_clr ? '0 : capture ? afu_nodes : nodes_latched;
        end
    bfs_sat_counter #(.W(CNT_W)) u_cycles (
        .clk  (clk),
        .rst  (SoftReset),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .count(run_cycles)
    );
endmodule

// File: doc/bfs_run_ctrl.md
BFS_RUN_CTRL -- requirements
Module: bfs_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 64: width of the cycle counter, cycle limit and node-count path.
REQ-002 SHALL have ports:
- clk  input  1  single clock.
- SoftReset  input  1  asynchronous, active-high reset.
- csr_go  input  1  run-request level from the CSR block.
- cfg_capacity  input  32  worklist capacity from the CSR block.
- cfg_max_cycles  input  CNT_W  cycle limit; 0 disables the timeout.
- start_worklist  output  1  one-cycle start pulse to the worklist service.
- wl_init_done  input  1  worklist service has finished initialising; sampled in INIT only.
- start_afu  output  1  one-cycle start pulse to the BFS engine.
- afu_finish  input  1  BFS engine completion, level or pulse.
- afu_nodes  input  CNT_W  nodes-touched count from the BFS engine.
- run_busy  output  1  high in INIT and RUN.
- run_done  output  1  high in DONE; this drives the CSR finish input.
- run_timeout  output  1  the run ended on the cycle limit.
- run_error  output  1  the run was rejected because cfg_capacity was 0.
- run_cycles  output  CNT_W  cycles spent in RUN.
- nodes_latched  output  CNT_W  afu_nodes captured at completion.

Function
REQ-003 SHALL implement a four-state FSM: IDLE, INIT, RUN, DONE.
REQ-004 SHALL treat a rising edge of csr_go as the start event. The edge is detected against a registered copy of csr_go.
REQ-005 IDLE, on a start event with cfg_capacity != 0:
- pulse start_worklist for exactly the next cycle;
- clear run_cycles, nodes_latched, run_timeout and run_error;
- enter INIT.
REQ-006 IDLE, on a start event with cfg_capacity == 0: set run_error, enter DONE, and issue no start pulses.
REQ-007 INIT, when wl_init_done is high: pulse start_afu for exactly one cycle and enter RUN. Dwell in INIT is unbounded.
REQ-008 RUN: run_cycles SHALL increment by 1 on every cycle in RUN and saturate at all-ones.
REQ-009 RUN, when afu_finish is high: capture afu_nodes into nodes_latched on that same edge and enter DONE.
REQ-010 RUN timeout: with cfg_max_cycles != 0 and run_cycles == cfg_max_cycles - 1 on an increment cycle, set run_timeout, capture afu_nodes, and enter DONE.
REQ-011 afu_finish and the timeout in the same cycle: finish SHALL win and run_timeout SHALL stay 0.
REQ-012 Abort: csr_go low while in INIT or RUN SHALL force IDLE on the next edge, with run_done staying 0 and the counters frozen.
REQ-013 DONE SHALL hold all status outputs stable until csr_go is low, then return to IDLE. The status stays readable in IDLE until the next start.
REQ-014 A csr_go held high through DONE and back to IDLE SHALL NOT restart a run. An explicit new rising edge is required.
REQ-015 start_worklist and start_afu SHALL each assert at most once per run and never in the same cycle.
REQ-016 All outputs SHALL be registered, giving one cycle of latency from the causing input edge.
REQ-017 cfg_capacity and cfg_max_cycles SHALL be sampled continuously; software must not change them while run_busy is high.

Reset
REQ-018 SoftReset SHALL asynchronously force IDLE and drive every output and the edge-detect register to 0, including while a run is in progress.
REQ-019 After SoftReset deasserts, a csr_go that is already high SHALL NOT start a run until it goes low and then high again.

Structure
REQ-020 A shared package bfs_run_pkg SHALL hold the state enum t_run_state and the CNT_W default constant.
REQ-021 A single sub-module, bfs_sat_counter (a saturating counter with clear and enable), SHALL implement run_cycles.

Verification
REQ-022 Nominal run: go 0->1, wl_init_done 3 cycles later, afu_finish 100 cycles after start_afu with afu_nodes=42 -> run_done=1, nodes_latched=42, run_cycles=100, run_timeout=0.
REQ-023 Timeout: cfg_max_cycles=50 and no afu_finish -> DONE after 50 RUN cycles, run_timeout=1, run_cycles=50.
REQ-024 Zero capacity: cfg_capacity=0 with a go edge -> run_error=1, run_done=1, and no start_worklist or start_afu pulse.
REQ-025 Simultaneous events: afu_finish in the same cycle as the timeout at cfg_max_cycles=20 -> run_timeout=0, run_done=1.
REQ-026 Abort and reset:
- go dropped in RUN -> IDLE with run_done=0;
- SoftReset asserted mid-RUN with go held high -> all outputs 0 and no restart until go toggles low then high.
REQ-027 Held go: go kept high through DONE -> exactly one start_worklist pulse and one start_afu pulse in total.
